// File: rtl/hit_pkg.sv
// Shared types and helpers for the hit cluster scanner: FSM states,
// neighbour-pattern width and a width helper for derived parameters.
package hit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int NEXT_W = 3;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hit_cluster_scanner_if.sv
// Hit stream from the scanner to the packet builder.
// Handshake: a hit transfers on a rising clk edge where hit_valid_o and
// hit_ready_i are both 1; while valid is high and ready low, hit_pos_o,
// hit_next_o and hit_last_o hold steady and valid stays high.
interface hit_cluster_scanner_if #(
  parameter int POS_W = 7
);
  import hit_pkg::*;

  logic              hit_valid_o;
  logic              hit_ready_i;
  logic [POS_W-1:0]  hit_pos_o;
  logic [NEXT_W-1:0] hit_next_o;
  logic              hit_last_o;

  modport master (
    output hit_valid_o,
    input  hit_ready_i,
    output hit_pos_o,
    output hit_next_o,
    output hit_last_o
  );

  modport slave (
    input  hit_valid_o,
    output hit_ready_i,
    input  hit_pos_o,
    input  hit_next_o,
    input  hit_last_o
  );

endinterface

// File: rtl/hit_priority_enc.sv
// MSB-first priority encoder: index of the highest set bit and an any-bit flag.
module hit_priority_enc
  import hit_pkg::*;
#(
  parameter int N = 128,
  parameter int W = width_of(N)
) (
  input  logic [N-1:0] d,
  output logic [W-1:0] pos,
  output logic         any
);

  // Ascending scan: the last set bit written is the highest one.
  always_comb begin
    pos = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        pos = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hit_cluster_scanner.sv
// Captures one strip hit map per event and serialises it one hit per
// handshake, highest strip first, optionally with a 3-bit lower-neighbour pattern.
module hit_cluster_scanner
  import hit_pkg::*;
#(
  parameter int N_STRIPS = 128,
  parameter int POS_W    = width_of(N_STRIPS),
  parameter int MAX_HITS = 64,
  parameter int CNT_W    = width_of(MAX_HITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [N_STRIPS-1:0] data_i,
  input  logic                cluster_mode_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                no_hits_o,
  output logic                overflow_o,
  output logic [CNT_W-1:0]    hit_count_o,
  output state_t              state_o,
  hit_cluster_scanner_if.master hit
);

  state_t              state_q, state_d;
  logic [N_STRIPS-1:0] map_q;
  logic                mode_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                overflow_q;
  logic                no_hits_q;

  logic [POS_W-1:0]    top_pos;
  logic                map_any;
  logic [N_STRIPS+2:0] ext_map;
  logic [N_STRIPS+2:0] clr_ext;
  logic [N_STRIPS-1:0] clr_mask;
  logic [N_STRIPS-1:0] remaining;
  logic [NEXT_W-1:0]   nb_bits;
  logic                is_last;
  logic                emit_valid;
  logic                accept;
  logic                load_ok;

  hit_priority_enc #(
    .N (N_STRIPS),
    .W (POS_W)
  ) u_enc (
    .d   (map_q),
    .pos (top_pos),
    .any (map_any)
  );

  // Three zero guard bits below strip 0 make pos-1..pos-3 read 0 off the end.
  assign ext_map  = {map_q, 3'b000};
  assign nb_bits  = NEXT_W'(ext_map >> top_pos);
  assign clr_ext  = {{(N_STRIPS - 1){1'b0}}, (mode_q ? 4'b1111 : 4'b1000)} << top_pos;
  assign clr_mask = N_STRIPS'(clr_ext >> 3);
  assign remaining = map_q & ~clr_mask;

  assign emit_valid = (state_q == EMIT) && map_any;
  assign is_last    = (remaining == '0) || (cnt_q == CNT_W'(MAX_HITS - 1));
  assign accept     = emit_valid && hit.hit_ready_i;
  assign load_ok    = (state_q == IDLE) && load_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    busy_o           = 1'b0;
    done_o           = 1'b0;
    no_hits_o        = 1'b0;
    hit.hit_valid_o  = 1'b0;
    hit.hit_pos_o    = '0;
    hit.hit_next_o   = '0;
    hit.hit_last_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) state_d = (data_i != '0) ? EMIT : FIN;
      end
      EMIT: begin
        busy_o          = 1'b1;
        hit.hit_valid_o = emit_valid;
        hit.hit_pos_o   = top_pos;
        hit.hit_next_o  = mode_q ? nb_bits : '0;
        hit.hit_last_o  = is_last;
        if (accept && is_last) state_d = FIN;
      end
      FIN: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        no_hits_o = no_hits_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_q      <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      no_hits_q  <= 1'b0;
    end else if (load_ok) begin
      map_q      <= data_i;
      mode_q     <= cluster_mode_i;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      no_hits_q  <= (data_i == '0);
    end else if (accept) begin
      map_q <= remaining;
      cnt_q <= cnt_q + CNT_W'(1);
      // Bits still set when the hit budget runs out mean the event was truncated.
      if (is_last && (remaining != '0)) overflow_q <= 1'b1;
    end
  end

  assign overflow_o  = overflow_q;
  assign hit_count_o = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_hit_cluster_scanner.sv
// Directed bench for hit_cluster_scanner: ordering, cluster patterns,
// truncation, stalls with ignored loads, and asynchronous reset mid-event.
module tb_hit_cluster_scanner;
  import hit_pkg::*;

  localparam int N_STRIPS = 128;
  localparam int POS_W    = 7;
  localparam int MAX_HITS = 64;
  localparam int CNT_W    = 7;

  logic                clk;
  logic                rst;
  logic                load_i;
  logic [N_STRIPS-1:0] data_i;
  logic                cluster_mode_i;
  logic                busy_o;
  logic                done_o;
  logic                no_hits_o;
  logic                overflow_o;
  logic [CNT_W-1:0]    hit_count_o;
  state_t              state_o;

  hit_cluster_scanner_if #(.POS_W(POS_W)) hif ();

  hit_cluster_scanner #(
    .N_STRIPS (N_STRIPS),
    .MAX_HITS (MAX_HITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load_i),
    .data_i         (data_i),
    .cluster_mode_i (cluster_mode_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .no_hits_o      (no_hits_o),
    .overflow_o     (overflow_o),
    .hit_count_o    (hit_count_o),
    .state_o        (state_o),
    .hit            (hif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [N_STRIPS-1:0] map, input logic mode);
    @(posedge clk); #1;
    load_i         = 1'b1;
    data_i         = map;
    cluster_mode_i = mode;
    @(posedge clk); #1;
    load_i = 1'b0;
    data_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy_o), 0);
    check({tag, "_valid"}, 32'(hif.hit_valid_o), 0);
    check({tag, "_pos"},   32'(hif.hit_pos_o), 0);
    check({tag, "_next"},  32'(hif.hit_next_o), 0);
    check({tag, "_last"},  32'(hif.hit_last_o), 0);
    check({tag, "_done"},  32'(done_o), 0);
    check({tag, "_nohit"}, 32'(no_hits_o), 0);
    check({tag, "_ovf"},   32'(overflow_o), 0);
    check({tag, "_cnt"},   32'(hit_count_o), 0);
    check({tag, "_state"}, 32'(state_o), 32'(IDLE));
  endtask

  logic [N_STRIPS-1:0] m;
  logic                done_seen;
  logic                stalled_prev;
  logic [POS_W-1:0]    prev_pos;

  initial begin
    rst             = 1'b1;
    load_i          = 1'b0;
    data_i          = '0;
    cluster_mode_i  = 1'b0;
    hif.hit_ready_i = 1'b1;
    #1;
    check_all_zero("reset");
    #12;
    rst = 1'b0;

    // ---- non-cluster {127,64,0} ----
    m = '0; m[127] = 1'b1; m[64] = 1'b1; m[0] = 1'b1;
    do_load(m, 1'b0);
    check("t1_busy", 32'(busy_o), 1);
    check("t1_v0", 32'(hif.hit_valid_o), 1);
    check("t1_p0", 32'(hif.hit_pos_o), 127);
    check("t1_l0", 32'(hif.hit_last_o), 0);
    check("t1_n0", 32'(hif.hit_next_o), 0);
    next_cycle();
    check("t1_p1", 32'(hif.hit_pos_o), 64);
    check("t1_l1", 32'(hif.hit_last_o), 0);
    next_cycle();
    check("t1_p2", 32'(hif.hit_pos_o), 0);
    check("t1_l2", 32'(hif.hit_last_o), 1);
    next_cycle();
    check("t1_done", 32'(done_o), 1);
    check("t1_vend", 32'(hif.hit_valid_o), 0);
    check("t1_nohit", 32'(no_hits_o), 0);
    check("t1_cnt", 32'(hit_count_o), 3);
    check("t1_busyfin", 32'(busy_o), 1);
    next_cycle();
    check("t1_idle", 32'(busy_o), 0);
    check("t1_donelow", 32'(done_o), 0);

    // ---- empty map ----
    do_load('0, 1'b0);
    check("t2_valid", 32'(hif.hit_valid_o), 0);
    check("t2_done", 32'(done_o), 1);
    check("t2_nohit", 32'(no_hits_o), 1);
    check("t2_cnt", 32'(hit_count_o), 0);
    next_cycle();
    check("t2_idle", 32'(busy_o), 0);
    check("t2_nohitlow", 32'(no_hits_o), 0);

    // ---- cluster mode {10,9,7,2,1} ----
    m = '0; m[10] = 1'b1; m[9] = 1'b1; m[7] = 1'b1; m[2] = 1'b1; m[1] = 1'b1;
    do_load(m, 1'b1);
    check("t3_p0", 32'(hif.hit_pos_o), 10);
    check("t3_n0", 32'(hif.hit_next_o), 32'b101);
    check("t3_l0", 32'(hif.hit_last_o), 0);
    next_cycle();
    check("t3_p1", 32'(hif.hit_pos_o), 2);
    check("t3_n1", 32'(hif.hit_next_o), 32'b100);
    check("t3_l1", 32'(hif.hit_last_o), 1);
    next_cycle();
    check("t3_done", 32'(done_o), 1);
    check("t3_cnt", 32'(hit_count_o), 2);

    // ---- all ones, truncated at MAX_HITS ----
    do_load('1, 1'b0);
    for (int i = 0; i < MAX_HITS; i++) begin
      check($sformatf("t4_p%0d", i), 32'(hif.hit_pos_o), 32'(127 - i));
      check($sformatf("t4_l%0d", i), 32'(hif.hit_last_o), 32'(i == MAX_HITS - 1));
      next_cycle();
    end
    check("t4_done", 32'(done_o), 1);
    check("t4_ovf", 32'(overflow_o), 1);
    check("t4_cnt", 32'(hit_count_o), 64);
    next_cycle();
    check("t4_idle", 32'(busy_o), 0);
    check("t4_ovfsticky", 32'(overflow_o), 1);

    // ---- random ready, load pulse during EMIT ----
    m = '0; m[100] = 1'b1; m[50] = 1'b1; m[33] = 1'b1; m[32] = 1'b1; m[7] = 1'b1; m[3] = 1'b1;
    exp_q = '{100, 50, 33, 32, 7, 3};
    do_load(m, 1'b0);
    check("t5_ovfclr", 32'(overflow_o), 0);
    done_seen    = 1'b0;
    stalled_prev = 1'b0;
    prev_pos     = '0;
    for (int it = 0; it < 300 && !done_seen; it++) begin
      if (done_o) begin
        done_seen = 1'b1;
      end else begin
        check("t5_valid", 32'(hif.hit_valid_o), 1);
        if (stalled_prev) check("t5_hold", 32'(hif.hit_pos_o), 32'(prev_pos));
        if (exp_q.size() > 0) begin
          check("t5_pos", 32'(hif.hit_pos_o), exp_q[0]);
          check("t5_last", 32'(hif.hit_last_o), 32'(exp_q.size() == 1));
        end
        hif.hit_ready_i = 1'($urandom_range(0, 1));
        load_i          = (it == 2);
        data_i          = (it == 2) ? '1 : '0;
        if (hif.hit_valid_o && hif.hit_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
        stalled_prev = hif.hit_valid_o && !hif.hit_ready_i;
        prev_pos     = hif.hit_pos_o;
        next_cycle();
        load_i = 1'b0;
        data_i = '0;
      end
    end
    check("t5_timeout", 32'(done_seen), 1);
    check("t5_qempty", 32'(exp_q.size()), 0);
    check("t5_cnt", 32'(hit_count_o), 6);
    check("t5_ovf", 32'(overflow_o), 0);
    hif.hit_ready_i = 1'b1;
    next_cycle();
    check("t5_idle", 32'(busy_o), 0);
    check("t5_novalid", 32'(hif.hit_valid_o), 0);

    // ---- async reset after two hits of five ----
    m = '0; m[40] = 1'b1; m[30] = 1'b1; m[20] = 1'b1; m[10] = 1'b1; m[5] = 1'b1;
    do_load(m, 1'b0);
    check("t6_p0", 32'(hif.hit_pos_o), 40);
    next_cycle();
    check("t6_p1", 32'(hif.hit_pos_o), 30);
    next_cycle();
    check("t6_p2", 32'(hif.hit_pos_o), 20);
    check("t6_cnt2", 32'(hit_count_o), 2);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    #2;
    rst = 1'b0;
    m = '0; m[5] = 1'b1;
    do_load(m, 1'b0);
    check("t6_np", 32'(hif.hit_pos_o), 5);
    check("t6_nl", 32'(hif.hit_last_o), 1);
    next_cycle();
    check("t6_ndone", 32'(done_o), 1);
    check("t6_ncnt", 32'(hit_count_o), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hit_cluster_scanner.md
# hit_cluster_scanner

Sequential, parametrised hit serializer for the readout data path. It captures one strip hit map per event and emits one hit per accepted handshake, highest strip first. In cluster mode each emitted hit carries its 3 lower-neighbour strip bits, which are consumed with it. The block sits between the event buffer readout and the packet builder, and replaces the single-shot combinational hit locator.

## Interface
- `N_STRIPS`, default 128: hit map width; must be a power of two, ≥ 8.
- `POS_W`, default $clog2(N_STRIPS): hit address width (derived; do not override).
- `MAX_HITS`, default 64: maximum hits emitted per event; further hits are truncated.
- `CNT_W`, default $clog2(MAX_HITS+1): hit counter width (derived).
- `clk`  in  1  single block clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_i`  in  1  capture `data_i` and `cluster_mode_i`; honoured only when `busy_o`=0.
- `data_i`  in  N_STRIPS  hit map; bit i = strip i.
- `cluster_mode_i`  in  1  1 = emit hit plus 3-bit next-strip pattern.
- `busy_o`  out  1  event in progress.
- `hit_valid_o`  out  1  hit presented.
- `hit_ready_i`  in  1  consumer accepts the hit.
- `hit_pos_o`  out  POS_W  strip address of the presented hit.
- `hit_next_o`  out  3  {strip pos-1, pos-2, pos-3}, with MSB = pos-1; forced 0 when cluster mode is off.
- `hit_last_o`  out  1  the presented hit is the final one of the event.
- `done_o`  out  1  one-cycle pulse at end of event.
- `no_hits_o`  out  1  valid with `done_o`: the event contained no hits.
- `overflow_o`  out  1  sticky: the event was truncated at MAX_HITS; cleared on next load.
- `hit_count_o`  out  CNT_W  hits accepted in the current or last event; cleared on load.

## Operation
- States: IDLE, EMIT, FIN.
- **IDLE**
  - `load_i`=1: register the map and mode, clear the count and `overflow_o`.
  - Map nonzero → EMIT. Map zero → FIN with `no_hits_o`=1.
- **EMIT**
  - An MSB-first priority encoder operates on the registered map. `hit_valid_o`=1 and `hit_pos_o`=highest set bit.
  - Neighbour bits with index < 0 read as 0.
  - On valid&ready:
    - Clear bit pos.
    - In cluster mode, also clear pos-1..pos-3.
    - Increment the count.
  - `hit_last_o` = (remaining map after the clear == 0) OR (count == MAX_HITS-1).
  - Accepted while last → FIN. If bits remained, set `overflow_o`.
- **FIN**: `done_o`=1 for one cycle, then → IDLE.
- `load_i` is ignored in EMIT and FIN. The registered map is unaffected.
- `hit_pos_o`, `hit_next_o` and `hit_last_o` are stable while valid and not ready. The map changes only on an accepted transfer.
- Non-cluster mode reports every set bit individually. Cluster mode reports strips pos-1..pos-3 as pattern bits only, never as separate hits.

## Timing
- Reset (async assert): state IDLE, map 0. All outputs 0: `busy_o`, `hit_valid_o`, `hit_pos_o`, `hit_next_o`, `hit_last_o`, `done_o`, `no_hits_o`, `overflow_o`, `hit_count_o`.
- Reset mid-event aborts the event immediately: no `done_o`, no partial output.
- Load accepted at edge k:
  - `busy_o`=1 and (if hits) `hit_valid_o`=1 from cycle k+1.
  - Empty map: `done_o`=`no_hits_o`=1 in cycle k+1, IDLE in k+2.
- Throughput: one hit per cycle while ready is held high. Hit n+1 is presented in the cycle after the acceptance of hit n.
- Last hit accepted at edge m: `done_o` in cycle m+1, `busy_o` drops in m+2. A load is accepted from m+2 onward.
- Event with H hits (H ≤ MAX_HITS), ready held high: busy for H+1 cycles.
- `no_hits_o` is a pulse qualified by `done_o`, reset to 0 on the next load.

## Structure
- Shared package `hit_pkg`:
  - state enum {IDLE, EMIT, FIN}
  - `NEXT_W`=3 constant
  - clog2-based width helper function
- Sub-module `hit_priority_enc`: combinational, parameter `N`. Outputs the highest set index and `any`. Instanced once on the registered map.
- Clear-mask generation and the FSM live in the top level. Target 150–250 lines.

## Test plan
- N=128, non-cluster, map bits {127,64,0}, ready=1 → pos 127, 64, 0 on consecutive cycles; last on 0; done at the next cycle; count=3.
- Map all-zero → no valid; `done_o`=`no_hits_o`=1 in cycle k+1; count=0.
- Cluster mode, map bits {10,9,7,2,1} → hit 10 with next=3'b101, then hit 2 with next=3'b100; last on 2.
- Map all-ones, MAX_HITS=64, non-cluster → 64 hits, pos 127 down to 64; last on 64; `overflow_o`=1; count=64.
- Ready toggled randomly, and `load_i` pulsed during EMIT → outputs held while stalled; the load is ignored; the hit sequence is identical to the ready=1 run.
- `rst` asserted after 2 hits of a 5-hit event → all outputs 0 asynchronously; a subsequent load of map {5} yields a single hit at pos 5.
